// File: rtl/axi4l_rd_master_q.sv
// rtl/axi4l_rd_master_q.sv - AXI4-Lite read master with up to MAX_OUT reads in flight,
// in-order registered responses and a sticky hung-slave watchdog.
module axi4l_rd_master_q #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int MAX_OUT = 2,
   parameter int TMO_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_prot,

   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [1:0]        resp_code,

   output logic              busy,
   output logic              timeout,

   output logic [ADDR_W-1:0] ar_addr,
   output logic              ar_valid,
   output logic [2:0]        ar_prot,
   input  logic              ar_ready,

   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   input  logic              r_valid,
   output logic              r_ready
);

   localparam int               CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

   logic [CNT_W-1:0] cnt;
   logic [TMO_W-1:0] wd;
   logic [TMO_W-1:0] wd_nxt;
   logic             req_fire;
   logic             ar_fire;
   logic             r_fire;

   // Gated by rst_n so both readies read 0 while reset is held, even before state settles.
   assign req_ready = rst_n && !timeout && (cnt < CNT_MAX) && (!ar_valid || ar_ready);
   assign r_ready   = rst_n && (cnt != '0) && (!resp_valid || resp_ready);

   assign req_fire  = req_valid && req_ready;
   assign ar_fire   = ar_valid && ar_ready;
   assign r_fire    = r_valid && r_ready;
   assign busy      = (cnt != '0);
   assign wd_nxt    = wd + TMO_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (req_fire && !r_fire) begin
         cnt <= cnt + CNT_W'(1);
      end else if (r_fire && !req_fire) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // A new request may reload the AR slot in the same cycle the previous one handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ar_valid <= 1'b0;
         ar_addr  <= '0;
         ar_prot  <= '0;
      end else if (req_fire) begin
         ar_valid <= 1'b1;
         ar_addr  <= req_addr;
         ar_prot  <= req_prot;
      end else if (ar_fire) begin
         ar_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_code  <= '0;
      end else if (r_fire) begin
         resp_valid <= 1'b1;
         resp_data  <= r_data;
         resp_code  <= r_resp;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

   // Counts cycles with reads pending and no R progress; saturates once the flag is raised.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else if ((cnt == '0) || r_fire) begin
         wd <= '0;
      end else if (wd != '1) begin
         wd <= wd_nxt;
         if (wd_nxt == '1) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi4l_rd_master_q.sv
// tb/tb_axi4l_rd_master_q.sv - self-checking bench for axi4l_rd_master_q with a
// behavioural slave, client scoreboard and cycle-level expectation model.
module tb_axi4l_rd_master_q;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int MO = 2;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic [2:0]    req_prot;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_data;
   logic [1:0]    resp_code;
   logic          busy, timeout;
   logic [AW-1:0] ar_addr;
   logic          ar_valid, ar_ready;
   logic [2:0]    ar_prot;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_valid, r_ready;

   always #5 clk = ~clk;

   axi4l_rd_master_q #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .TMO_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_prot(req_prot),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_code(resp_code),
      .busy(busy), .timeout(timeout),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_prot(ar_prot), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
   );

   typedef struct { logic [63:0] addr; logic [2:0] prot; } req_t;
   typedef struct { logic [63:0] addr; int due; } slv_t;

   int checks = 0;
   int errors = 0;

   req_t        req_list[$];
   req_t        m_ar_q[$];
   slv_t        slv_q[$];
   logic [63:0] m_sb[$];
   int          m_cnt = 0;
   int          m_idle = 0;
   bit          m_rv = 0;
   bit          m_to = 0;
   int          cyc = 0;

   int ar_p = 100, rr_p = 100, rdly_lo = 0, rdly_hi = 0;
   bit slv_mute = 0, junk_r = 0;

   logic [63:0] got_d[$];
   logic [1:0]  got_c[$];
   logic [63:0] last_ar_addr;
   int n_ar_hs, n_arstall, n_rstall, n_reqstall, t_acc, t_rv, t_to;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] data_of(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
      return {a[31:0] ^ 32'h5A5A_C3C3, a[63:32] + a[31:0] * 32'd3 + 32'h0F0F_1234};
   endfunction

   function automatic logic [1:0] resp_of(input logic [63:0] a);
      return a[7:6];
   endfunction

   function automatic logic [63:0] gd(input int i);
      return (i < got_d.size()) ? got_d[i] : 64'hx;
   endfunction

   function automatic logic [63:0] gc(input int i);
      return (i < got_c.size()) ? 64'(got_c[i]) : 64'hx;
   endfunction

   task automatic push_req(input logic [63:0] a, input logic [2:0] p);
      req_t r;
      r.addr = a;
      r.prot = p;
      req_list.push_back(r);
   endtask

   task automatic clr_obs();
      got_d.delete(); got_c.delete();
      n_ar_hs = 0; n_arstall = 0; n_rstall = 0; n_reqstall = 0;
      t_acc = -1; t_rv = -1; t_to = -1; last_ar_addr = '0;
   endtask

   // One clock: drive inputs at negedge, check outputs against the model, advance the model.
   task automatic tick();
      bit   e_req_rdy, e_r_rdy, ar_v, req_hs, ar_hs, r_hs, resp_hs;
      slv_t s;
      @(negedge clk);
      if (req_list.size() > 0) begin
         req_valid = 1'b1; req_addr = req_list[0].addr; req_prot = req_list[0].prot;
      end else begin
         req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_prot = 3'($urandom);
      end
      ar_ready = ($urandom_range(99) < ar_p);
      if (!slv_mute && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
         r_valid = 1'b1; r_data = data_of(slv_q[0].addr); r_resp = resp_of(slv_q[0].addr);
      end else begin
         r_valid = junk_r && (m_cnt == 0) && ($urandom_range(1) == 1);
         r_data = {$urandom, $urandom}; r_resp = 2'($urandom);
      end
      resp_ready = ($urandom_range(99) < rr_p);
      #1;
      ar_v      = (m_ar_q.size() > 0);
      e_req_rdy = !m_to && (m_cnt < MO) && (!ar_v || ar_ready);
      e_r_rdy   = (m_cnt != 0) && (!m_rv || resp_ready);
      chk("req_ready", 64'(req_ready), 64'(e_req_rdy));
      chk("r_ready", 64'(r_ready), 64'(e_r_rdy));
      chk("ar_valid", 64'(ar_valid), 64'(ar_v));
      if (ar_v) begin
         chk("ar_addr", ar_addr, m_ar_q[0].addr);
         chk("ar_prot", 64'(ar_prot), 64'(m_ar_q[0].prot));
      end
      chk("resp_valid", 64'(resp_valid), 64'(m_rv));
      if (m_rv) begin
         chk("resp_data", resp_data, data_of(m_sb[0]));
         chk("resp_code", 64'(resp_code), 64'(resp_of(m_sb[0])));
      end
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("timeout", 64'(timeout), 64'(m_to));

      if (ar_valid && ar_ready) begin n_ar_hs++; last_ar_addr = ar_addr; end
      if (ar_valid && !ar_ready) n_arstall++;
      if (resp_valid && resp_ready) begin got_d.push_back(resp_data); got_c.push_back(resp_code); end
      if (r_valid && !r_ready && m_cnt != 0) n_rstall++;
      if (req_valid && !req_ready) n_reqstall++;
      if (resp_valid && t_rv < 0) t_rv = cyc;
      if (timeout && t_to < 0) t_to = cyc;

      req_hs  = req_valid && e_req_rdy;
      ar_hs   = ar_v && ar_ready;
      r_hs    = r_valid && e_r_rdy;
      resp_hs = m_rv && resp_ready;

      if (m_cnt == 0 || r_hs) m_idle = 0;
      else m_idle++;
      if (m_idle >= (1 << TW) - 1) m_to = 1;

      if (ar_hs) begin
         s.addr = m_ar_q[0].addr;
         s.due  = cyc + 1 + int'($urandom_range(rdly_hi, rdly_lo));
         slv_q.push_back(s);
         void'(m_ar_q.pop_front());
      end
      if (req_hs) begin
         m_ar_q.push_back(req_list[0]);
         m_sb.push_back(req_list[0].addr);
         void'(req_list.pop_front());
         m_cnt++;
         t_acc = cyc;
      end
      if (r_hs) begin void'(slv_q.pop_front()); m_cnt--; end
      if (resp_hs) void'(m_sb.pop_front());
      if (r_hs) m_rv = 1;
      else if (resp_hs) m_rv = 0;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n = 1'b0; req_valid = 1'b1; req_addr = {$urandom, $urandom}; req_prot = 3'($urandom);
         ar_ready = 1'b1; r_valid = 1'b1; r_data = {$urandom, $urandom}; r_resp = 2'b10; resp_ready = 1'b1;
         #1;
         chk("rst_req_ready", 64'(req_ready), 64'(0));
         chk("rst_r_ready", 64'(r_ready), 64'(0));
         if (i > 0) begin
            chk("rst_ar_valid", 64'(ar_valid), 64'(0));
            chk("rst_ar_addr", ar_addr, 64'(0));
            chk("rst_ar_prot", 64'(ar_prot), 64'(0));
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_resp_data", resp_data, 64'(0));
            chk("rst_resp_code", 64'(resp_code), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_timeout", 64'(timeout), 64'(0));
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1; req_valid = 1'b0; r_valid = 1'b0;
      req_list.delete(); m_ar_q.delete(); slv_q.delete(); m_sb.delete();
      m_cnt = 0; m_idle = 0; m_rv = 0; m_to = 0;
   endtask

   task automatic drain(input int lim);
      int n = 0;
      while ((req_list.size() != 0 || m_cnt != 0 || m_rv) && n < lim) begin
         tick();
         n++;
      end
      chk("drain_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int npush;
      req_valid = 0; req_addr = '0; req_prot = '0; ar_ready = 0;
      r_valid = 0; r_data = '0; r_resp = '0; resp_ready = 0;
      do_reset(3);

      // single read, best-case round trip
      clr_obs(); ar_p = 100; rr_p = 100; rdly_lo = 0; rdly_hi = 0;
      push_req(64'h8000_0000, 3'b010);
      drain(30);
      chk("single_ar_addr", last_ar_addr, 64'h8000_0000);
      chk("single_ar_count", 64'(n_ar_hs), 64'(1));
      chk("single_latency", 64'(t_rv - t_acc), 64'(3));
      chk("single_data", gd(0), 64'h1122_3344_5566_7788);
      chk("single_code", gc(0), 64'(0));

      // pipelined reads against a slow slave
      clr_obs(); rdly_lo = 4; rdly_hi = 4;
      push_req(64'h0, 3'd0); push_req(64'h8, 3'd0); push_req(64'h10, 3'd0);
      drain(60);
      chk("pipe_stall_cycles", 64'(n_reqstall), 64'(5));
      chk("pipe_order0", gd(0), data_of(64'h0));
      chk("pipe_order1", gd(1), data_of(64'h8));
      chk("pipe_order2", gd(2), data_of(64'h10));

      // AR stall for five cycles
      clr_obs(); rdly_lo = 0; rdly_hi = 0; ar_p = 0;
      push_req(64'h1000_0040, 3'd5);
      tick();
      push_req(64'h1000_0048, 3'd3);
      for (int i = 0; i < 5; i++) tick();
      ar_p = 100;
      drain(20);
      chk("arstall_cycles", 64'(n_arstall), 64'(5));
      chk("arstall_req_blocked", 64'(n_reqstall), 64'(5));
      chk("arstall_ar_count", 64'(n_ar_hs), 64'(2));

      // response backpressure with a second beat waiting
      clr_obs(); rr_p = 0;
      push_req(64'h2000_0000, 3'd1); push_req(64'h2000_0008, 3'd1);
      for (int i = 0; i < 20 && t_rv < 0; i++) tick();
      n_rstall = 0;
      for (int i = 0; i < 3; i++) tick();
      chk("bp_r_ready_low", 64'(n_rstall), 64'(3));
      rr_p = 100;
      drain(20);
      chk("bp_count", 64'(got_d.size()), 64'(2));
      chk("bp_data0", gd(0), data_of(64'h2000_0000));
      chk("bp_data1", gd(1), data_of(64'h2000_0008));

      // SLVERR then DECERR pass through
      clr_obs();
      push_req(64'h4000_0080, 3'd0); push_req(64'h4000_00C0, 3'd0);
      drain(30);
      chk("err_code0", gc(0), 64'(2));
      chk("err_code1", gc(1), 64'(3));
      chk("err_data0", gd(0), data_of(64'h4000_0080));
      chk("err_data1", gd(1), data_of(64'h4000_00C0));

      // randomized traffic with stray r_valid while idle
      clr_obs(); npush = 0; junk_r = 1; ar_p = 75; rr_p = 80; rdly_lo = 0; rdly_hi = 3;
      for (int i = 0; i < 400; i++) begin
         if (req_list.size() < 2 && $urandom_range(99) < 60) begin
            push_req({$urandom, $urandom} & ~64'h7, 3'($urandom));
            npush++;
         end
         tick();
      end
      junk_r = 0; ar_p = 100; rr_p = 100;
      drain(100);
      chk("rand_resp_count", 64'(got_d.size()), 64'(npush));

      // reset with reads in flight
      rdly_lo = 6; rdly_hi = 6;
      push_req(64'h5000_0000, 3'd0); push_req(64'h5000_0008, 3'd0);
      for (int i = 0; i < 4; i++) tick();
      do_reset(2);

      // watchdog against a mute slave
      clr_obs(); rdly_lo = 0; rdly_hi = 0; slv_mute = 1;
      push_req(64'h3000_0000, 3'd0);
      for (int i = 0; i < 40 && t_to < 0; i++) tick();
      chk("wd_fire_cycle", 64'(t_to - t_acc), 64'(16));
      push_req(64'h3000_0100, 3'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("wd_req_blocked", 64'(n_reqstall), 64'(5));
      slv_mute = 0;
      for (int i = 0; i < 20 && got_d.size() == 0; i++) tick();
      chk("wd_late_data", gd(0), data_of(64'h3000_0000));
      chk("wd_drained_busy", 64'(busy), 64'(0));
      chk("wd_sticky", 64'(timeout), 64'(1));
      tick();
      do_reset(2);

      // traffic resumes after reset
      clr_obs();
      push_req(64'h6000_0008, 3'd4);
      drain(30);
      chk("post_rst_data", gd(0), data_of(64'h6000_0008));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4l_rd_master_q.md
# axi4l_rd_master_q

Parametrised AXI4-Lite read master that replaces the single-shot, level-triggered read master. It accepts read requests on a valid/ready client port and issues them on the AR channel with up to MAX_OUT reads in flight. Responses return in order on a registered valid/ready response port with the RRESP code. A watchdog flags a hung slave. The block sits between the core's load/fetch units and the AXI4-Lite arbiter.

## Interface
- ADDR_W, 64, address width.
- DATA_W, 64, data width (32 or 64).
- MAX_OUT, 2, maximum reads in flight (1..15).
- TMO_W, 8, watchdog counter width; timeout fires at 2^TMO_W-1 idle cycles.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  client read request valid.
- req_ready  out  1  request accepted this cycle when both high.
- req_addr  in  ADDR_W  read address, sampled on accept.
- req_prot  in  3  AxPROT value, sampled on accept.
- resp_valid  out  1  response data valid.
- resp_ready  in  1  client takes response.
- resp_data  out  DATA_W  read data.
- resp_code  out  2  RRESP of this beat.
- busy  out  1  one or more reads outstanding.
- timeout  out  1  sticky watchdog flag.
- ar_addr  out  ADDR_W  AXI read address.
- ar_valid  out  1  AXI AR valid.
- ar_prot  out  3  AXI AR prot.
- ar_ready  in  1  AXI AR ready.
- r_data  in  DATA_W  AXI read data.
- r_resp  in  2  AXI read response.
- r_valid  in  1  AXI R valid.
- r_ready  out  1  AXI R ready.

## Operation
- **Outstanding counter `cnt`** (width ceil(log2(MAX_OUT+1))):
  - +1 on a request accept; -1 on an R handshake (r_valid && r_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT; never underflows.
  - An r_valid arriving with cnt==0 is ignored, and r_ready stays 0 in that case.
- **AR register:** holds ar_addr, ar_prot and ar_valid.
  - Loaded on a request accept: ar_valid<=1.
  - Cleared on an AR handshake unless reloaded in the same cycle.
  - ar_addr and ar_prot stay stable while ar_valid && !ar_ready.
- **req_ready** = !timeout && (cnt < MAX_OUT) && (!ar_valid || ar_ready). Combinational; not a function of req_valid.
- **Response register:** holds resp_valid, resp_data and resp_code.
  - r_ready = (cnt != 0) && (!resp_valid || resp_ready).
  - On an R handshake, r_data and r_resp are captured and resp_valid<=1.
  - Otherwise resp_valid clears on resp_ready.
- **Ordering:** AXI4-Lite returns responses in order, so responses map to requests FIFO-wise. There is no ID tracking.
- **busy** = (cnt != 0).
- **Watchdog:** counter `wd` resets to 0 whenever cnt==0 or an R handshake occurs; otherwise it increments.
  - At all-ones, timeout<=1. timeout is sticky until reset.
  - When timeout=1, req_ready=0. Traffic already in flight still drains normally.
- **Error handling:** SLVERR (2'b10) and DECERR (2'b11) are passed through unchanged on resp_code. The master does not retry.

## Timing
- **Reset values:** ar_valid=0, ar_addr=0, ar_prot=0, r_ready=0, req_ready=0 during reset, resp_valid=0, resp_data=0, resp_code=0, busy=0, timeout=0, cnt=0, wd=0.
- **Reset mid-transaction:** all state is dropped on the reset cycle. The slave side is reset by the same rst_n.
- **AR latency:** request accepted at cycle N gives ar_valid=1 at N+1.
- **Response latency:** R handshake at cycle M gives resp_valid=1 at M+1.
- **Best-case round trip:** ar_ready=1 at N+1 and r_valid at N+2 gives resp_valid at N+3.
- **Back-to-back:** with ar_ready tied high and cnt<MAX_OUT, one request per cycle is accepted.
- **Full throughput:** with resp_ready tied high, one response per cycle is delivered.
- **Backpressure:** resp_valid && !resp_ready forces r_ready=0 in the same cycle. The slave holds r_data.
- **Full:** cnt==MAX_OUT gives req_ready=0. An R handshake in a cycle does not raise req_ready in that same cycle; it rises the next cycle.

## Test plan
- **Single read:** req_addr=0x8000_0000, ar_ready=1, slave returns r_data=0x1122334455667788, r_resp=0 two cycles later.
  -> One AR beat with that address; resp_valid one cycle after the R handshake with the same data; resp_code=0.
- **Pipelined reads (MAX_OUT=2):** three back-to-back requests to 0x0, 0x8, 0x10; slave delays R by 4 cycles.
  -> Third request stalls (req_ready=0) until the first R handshake.
  -> Responses arrive in order 0x0, 0x8, 0x10.
- **AR stall:** ar_ready=0 for 5 cycles.
  -> ar_addr/ar_prot stable, ar_valid held high, req_ready=0; single AR handshake on the 6th cycle.
- **Response backpressure:** resp_ready=0 for 3 cycles with a second R beat pending.
  -> r_ready=0 for those cycles; resp_data unchanged; no beat lost or duplicated.
- **Error passthrough:** r_resp=2'b10, then 2'b11.
  -> resp_code=2 then 3 with data passed through; cnt returns to 0.
- **Watchdog (TMO_W=4):** one request issued, slave never asserts r_valid.
  -> timeout=1 after 15 idle cycles and req_ready=0; a late R beat still drains; timeout stays 1 until rst_n=0.
